// File: rtl/line_render_scheduler.sv
// Line render scheduler: round-robin arbitration of six draw/erase engines onto
// one VGA pixel-write port, one span per requesting lane per render pass.
module line_render_scheduler #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frame_go,
   input  logic [5:0]  req,
   input  logic [5:0]  done,
   input  logic [53:0] x_in,
   input  logic [47:0] y_in,
   input  logic [5:0]  colour_in,
   output logic [5:0]  grant,
   output logic [8:0]  x_out,
   output logic [7:0]  y_out,
   output logic [2:0]  colour_out,
   output logic        vga_enable,
   output logic        busy,
   output logic        pass_done,
   output logic        timeout_err
);

   // Handshake: an engine owns the pixel port while its grant bit is high; it
   // ends the span by raising its done bit for a cycle while still granted, and
   // the grant drops on the following edge. Done from any other lane is ignored.

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCAN   = 3'd1,
      SERVE  = 3'd2,
      GAP    = 3'd3,
      FINISH = 3'd4
   } state_t;

   localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic [5:0]  pending;
   logic [2:0]  last;
   logic [9:0]  cnt;
   logic        frame_go_q;

   logic        start_edge;
   logic [3:0]  cand;
   logic [2:0]  pick_idx;
   logic [5:0]  pick_onehot;
   logic [2:0]  gidx;
   logic        done_hit;
   logic        at_limit;
   logic        serve_exit;

   assign start_edge = frame_go & ~frame_go_q;
   assign done_hit   = |(done & grant);
   assign at_limit   = (cnt == CNT_LAST);
   assign serve_exit = done_hit | at_limit;

   // Walk offsets from far to near so the nearest pending lane after 'last' wins.
   always_comb begin
      pick_idx = 3'd0;
      cand     = 4'd0;
      for (int off = 6; off >= 1; off--) begin
         cand = {1'b0, last} + 4'(off);
         if (cand >= 4'd6) begin
            cand = cand - 4'd6;
         end
         if (pending[cand[2:0]]) begin
            pick_idx = cand[2:0];
         end
      end
      pick_onehot = 6'b000001 << pick_idx;
   end

   always_comb begin
      gidx = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (grant[i]) begin
            gidx = 3'(i);
         end
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start_edge) begin
               state_next = (req != 6'd0) ? SCAN : FINISH;
            end
         end
         SCAN:   state_next = SERVE;
         SERVE: begin
            if (serve_exit) begin
               state_next = GAP;
            end
         end
         GAP:    state_next = (pending != 6'd0) ? SCAN : FINISH;
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pass bookkeeping: pending set, grant, round-robin pointer, service timer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending     <= 6'd0;
         grant       <= 6'd0;
         last        <= 3'd5;
         cnt         <= 10'd0;
         frame_go_q  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         frame_go_q <= frame_go;
         case (state)
            IDLE: begin
               if (start_edge) begin
                  pending <= req;
               end
            end
            SCAN: begin
               grant <= pick_onehot;
               cnt   <= 10'd0;
            end
            SERVE: begin
               cnt <= cnt + 10'd1;
               if (serve_exit) begin
                  pending <= pending & ~grant;
                  last    <= gidx;
                  grant   <= 6'd0;
                  if (!done_hit) begin
                     timeout_err <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs; the pixel mux follows the registered grant so reset clears it at once.
   always_comb begin
      busy       = (state != IDLE);
      pass_done  = (state == FINISH);
      vga_enable = |grant;
      x_out      = 9'd0;
      y_out      = 8'd0;
      colour_out = 3'b111;
      for (int i = 0; i < 6; i++) begin
         if (grant[i]) begin
            x_out      = x_in[9*i +: 9];
            y_out      = y_in[8*i +: 8];
            colour_out = {3{colour_in[i]}};
         end
      end
   end

endmodule

// File: tb/tb_line_render_scheduler.sv
// Bench for line_render_scheduler: per-cycle trace scoreboard for whole passes,
// a vector table for the pixel mux, and hand sequences for timeout and reset.
module tb_line_render_scheduler;

   localparam int T = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        frame_go;
   logic [5:0]  req;
   logic [5:0]  done = 6'd0;
   logic [53:0] x_in;
   logic [47:0] y_in;
   logic [5:0]  colour_in;
   logic [5:0]  grant;
   logic [8:0]  x_out;
   logic [7:0]  y_out;
   logic [2:0]  colour_out;
   logic        vga_enable;
   logic        busy;
   logic        pass_done;
   logic        timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Trace entry: {busy, timeout_err, pass_done, vga_enable, grant}
   logic [9:0] exp_q[$];
   logic       te_exp;

   logic eng_en;
   int   eng_delay;
   logic noise;
   int   eng_cnt [6];

   typedef struct {
      int         lane;
      logic [8:0] x;
      logic [7:0] y;
      logic       c;
      logic [5:0] exp_grant;
      logic [8:0] exp_x;
      logic [7:0] exp_y;
      logic [2:0] exp_col;
   } mux_vec_t;

   mux_vec_t vecs [6];

   line_render_scheduler #(.TIMEOUT_CYCLES(T)) dut (
      .clock       (clock),
      .reset       (reset),
      .frame_go    (frame_go),
      .req         (req),
      .done        (done),
      .x_in        (x_in),
      .y_in        (y_in),
      .colour_in   (colour_in),
      .grant       (grant),
      .x_out       (x_out),
      .y_out       (y_out),
      .colour_out  (colour_out),
      .vga_enable  (vga_enable),
      .busy        (busy),
      .pass_done   (pass_done),
      .timeout_err (timeout_err)
   );

   // Clock / reset
   always #5 clock = ~clock;

   // Engine model: the granted lane raises done on its eng_delay-th grant cycle;
   // with noise set, every non-granted lane holds done high.
   always @(negedge clock) begin
      for (int i = 0; i < 6; i++) begin
         if (eng_en && grant[i]) eng_cnt[i] = eng_cnt[i] + 1;
         else                    eng_cnt[i] = 0;
         done[i] = (eng_en && grant[i] && eng_cnt[i] == eng_delay) || (noise && !grant[i]);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic q_push(input logic [5:0] g, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({1'b1, te_exp, 1'b0, |g, g});
   endtask

   task automatic q_finish();
      exp_q.push_back({1'b1, te_exp, 1'b1, 1'b0, 6'd0});
      exp_q.push_back({1'b0, te_exp, 1'b0, 1'b0, 6'd0});
   endtask

   task automatic start_pass(input logic [5:0] r);
      @(negedge clock);
      frame_go = 1'b1;
      req      = r;
      @(negedge clock);
      frame_go = 1'b0;
   endtask

   // Starts a pass and compares every following cycle against the queued trace.
   task automatic run_pass(input logic [5:0] r, input int glitch);
      int         idx;
      logic [9:0] exp;
      logic [9:0] got;
      start_pass(r);
      idx = 0;
      while (exp_q.size() > 0) begin
         if (idx > 0) @(negedge clock);
         exp = exp_q.pop_front();
         got = {busy, timeout_err, pass_done, vga_enable, grant};
         check($sformatf("trace[%0d]", idx), 32'(got), 32'(exp));
         if (idx == glitch) begin
            frame_go = 1'b1;
            req      = 6'h3f;
         end else if (idx == glitch + 1) begin
            frame_go = 1'b0;
         end
         idx++;
      end
      frame_go = 1'b0;
      req      = 6'd0;
   endtask

   task automatic wait_grant(input int max);
      int k = 0;
      while (grant == 6'd0 && k < max) begin
         @(negedge clock);
         k++;
      end
      check("grant_wait", 32'(grant != 6'd0), 32'd1);
   endtask

   task automatic wait_pd(input int max);
      int k = 0;
      while (!pass_done && k < max) begin
         @(negedge clock);
         k++;
      end
      check("pass_done_wait", 32'(pass_done), 32'd1);
   endtask

   task automatic set_lanes(input mux_vec_t v);
      for (int j = 0; j < 6; j++) begin
         x_in[9*j +: 9] = 9'(100 + 37 * j);
         y_in[8*j +: 8] = 8'(200 + j);
         colour_in[j]   = ~v.c;
      end
      x_in[9*v.lane +: 9] = v.x;
      y_in[8*v.lane +: 8] = v.y;
      colour_in[v.lane]   = v.c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{lane: 3, x: 9'd150, y: 8'd127, c: 1'b0, exp_grant: 6'b001000, exp_x: 9'd150, exp_y: 8'd127, exp_col: 3'b000};
      vecs[1] = '{lane: 0, x: 9'd511, y: 8'd255, c: 1'b1, exp_grant: 6'b000001, exp_x: 9'd511, exp_y: 8'd255, exp_col: 3'b111};
      vecs[2] = '{lane: 5, x: 9'd0,   y: 8'd1,   c: 1'b1, exp_grant: 6'b100000, exp_x: 9'd0,   exp_y: 8'd1,   exp_col: 3'b111};
      vecs[3] = '{lane: 1, x: 9'd256, y: 8'd128, c: 1'b0, exp_grant: 6'b000010, exp_x: 9'd256, exp_y: 8'd128, exp_col: 3'b000};
      vecs[4] = '{lane: 2, x: 9'd85,  y: 8'd170, c: 1'b1, exp_grant: 6'b000100, exp_x: 9'd85,  exp_y: 8'd170, exp_col: 3'b111};
      vecs[5] = '{lane: 4, x: 9'd300, y: 8'd42,  c: 1'b0, exp_grant: 6'b010000, exp_x: 9'd300, exp_y: 8'd42,  exp_col: 3'b000};

      reset     = 1'b1;
      frame_go  = 1'b0;
      req       = 6'd0;
      x_in      = 54'd0;
      y_in      = 48'd0;
      colour_in = 6'd0;
      eng_en    = 1'b0;
      eng_delay = 3;
      noise     = 1'b0;
      te_exp    = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      check("rst_grant", 32'(grant), 32'd0);
      check("rst_x_out", 32'(x_out), 32'd0);
      check("rst_y_out", 32'(y_out), 32'd0);
      check("rst_colour_out", 32'(colour_out), 32'h7);
      check("rst_vga_enable", 32'(vga_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pass_done", 32'(pass_done), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);

      // Empty pass: FINISH straight after the start edge, no grant.
      q_finish();
      run_pass(6'b000000, -1);

      // Three lanes, 3-cycle spans; a mid-pass start edge with req=111111 is ignored.
      do_reset();
      eng_en = 1'b1;
      eng_delay = 3;
      q_push(6'd0, 1);
      q_push(6'b000001, 3);
      q_push(6'd0, 2);
      q_push(6'b000100, 3);
      q_push(6'd0, 2);
      q_push(6'b100000, 3);
      q_push(6'd0, 1);
      q_finish();
      run_pass(6'b100101, 2);

      // Round-robin pointer across passes, with stray done on non-granted lanes.
      do_reset();
      eng_delay = 2;
      noise = 1'b1;
      q_push(6'd0, 1);
      q_push(6'b000100, 2);
      q_push(6'd0, 1);
      q_finish();
      run_pass(6'b000100, -1);
      q_push(6'd0, 1);
      q_push(6'b000001, 2);
      q_push(6'd0, 2);
      q_push(6'b000100, 2);
      q_push(6'd0, 1);
      q_finish();
      run_pass(6'b000101, -1);
      noise = 1'b0;

      // Done arriving on the final allowed cycle beats the timeout.
      do_reset();
      eng_delay = T;
      q_push(6'd0, 1);
      q_push(6'b000010, T);
      q_push(6'd0, 1);
      q_finish();
      run_pass(6'b000010, -1);

      // Timeout: grant held exactly T cycles, sticky error through a clean pass.
      eng_en = 1'b0;
      te_exp = 1'b0;
      q_push(6'd0, 1);
      q_push(6'b000010, T);
      te_exp = 1'b1;
      q_push(6'd0, 1);
      q_finish();
      run_pass(6'b000010, -1);
      eng_en = 1'b1;
      eng_delay = 3;
      q_push(6'd0, 1);
      q_push(6'b000001, 3);
      q_push(6'd0, 1);
      q_finish();
      run_pass(6'b000001, -1);

      // Pixel mux table; reset first also clears the sticky error.
      do_reset();
      te_exp = 1'b0;
      check("te_cleared_by_reset", 32'(timeout_err), 32'd0);
      eng_delay = 2;
      for (int v = 0; v < 6; v++) begin
         set_lanes(vecs[v]);
         start_pass(6'b000001 << vecs[v].lane);
         wait_grant(4);
         check($sformatf("mux%0d_grant", v), 32'(grant), 32'(vecs[v].exp_grant));
         check($sformatf("mux%0d_x", v), 32'(x_out), 32'(vecs[v].exp_x));
         check($sformatf("mux%0d_y", v), 32'(y_out), 32'(vecs[v].exp_y));
         check($sformatf("mux%0d_colour", v), 32'(colour_out), 32'(vecs[v].exp_col));
         check($sformatf("mux%0d_vga", v), 32'(vga_enable), 32'd1);
         wait_pd(10);
         check($sformatf("mux%0d_idle_x", v), 32'(x_out), 32'd0);
         check($sformatf("mux%0d_idle_y", v), 32'(y_out), 32'd0);
         check($sformatf("mux%0d_idle_colour", v), 32'(colour_out), 32'h7);
         req = 6'd0;
      end

      // Reset between clock edges while lane 3 is being served.
      eng_en = 1'b0;
      set_lanes(vecs[0]);
      start_pass(6'b001000);
      wait_grant(4);
      check("pre_rst_x", 32'(x_out), 32'd150);
      check("pre_rst_y", 32'(y_out), 32'd127);
      check("pre_rst_colour", 32'(colour_out), 32'h0);
      check("pre_rst_vga", 32'(vga_enable), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_grant", 32'(grant), 32'd0);
      check("async_rst_x", 32'(x_out), 32'd0);
      check("async_rst_y", 32'(y_out), 32'd0);
      check("async_rst_colour", 32'(colour_out), 32'h7);
      check("async_rst_vga", 32'(vga_enable), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      req = 6'd0;
      eng_en = 1'b1;
      q_finish();
      run_pass(6'b000000, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
